vram_cpu_port: RTL and testbench

- CPU-side access port into the 8 KiB video RAM. It sits upstream of the video generator's RAM and shares the RAM's single port with the generator's pixel fetch.
- CPU writes are buffered in a small FIFO and drained into RAM only on cycles the generator does not claim the port.
- CPU reads are ordered behind pending writes and return data through a one-cycle synchronous RAM read.

---
 rtl/vram_cpu_port.sv | 141 ++++++++++++++
 tb/tb_vram_cpu_port.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_cpu_port.sv
// rtl/vram_cpu_port.sv - CPU access port into shared video RAM with buffered writes; optional VRAM_READ_FORWARD_EN
module vram_cpu_port #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_wr_req,
  input  logic                    cpu_rd_req,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  output logic                    cpu_busy,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    cpu_rd_valid,
  input  logic                    video_fetch,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  output logic                    ram_we,
  output logic                    ram_re,
  input  logic [DATA_WIDTH-1:0]   ram_rdata,
  output logic [$clog2(DEPTH):0]  fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {RD_IDLE, RD_DRAIN, RD_ISSUE, RD_WAIT} rd_state_t;

  rd_state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] fifo_addr [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic full, empty, free_slot;
  logic wr_accept, rd_accept, pop, issue;
  logic [DATA_WIDTH-1:0] rd_result;

  assign full       = (level == LW'(DEPTH));
  assign empty      = (level == '0);
  assign free_slot  = !video_fetch;
  assign cpu_busy   = full || (state != RD_IDLE);
  assign wr_accept  = cpu_wr_req && !cpu_busy;
  assign rd_accept  = cpu_rd_req && !cpu_wr_req && !cpu_busy;
  // The RAM port is idle while a read is being issued, so drain and issue never collide.
  assign pop        = free_slot && !empty && (state != RD_ISSUE);
  assign issue      = free_slot && (state == RD_ISSUE);
  assign fifo_level = level;

  assign ram_we    = pop;
  assign ram_re    = issue;
  assign ram_addr  = pop ? fifo_addr[rd_ptr] : (issue ? rd_addr : '0);
  assign ram_wdata = pop ? fifo_data[rd_ptr] : '0;

`ifdef VRAM_READ_FORWARD_EN
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic                  fwd_sel;
  logic [DATA_WIDTH-1:0] fwd_data_q;

  // Scan oldest to newest so the newest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((LW'(i) < level) && (fifo_addr[rd_ptr + PW'(i)] == cpu_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_data[rd_ptr + PW'(i)];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_sel    <= 1'b0;
      fwd_data_q <= '0;
    end else if (rd_accept) begin
      fwd_sel    <= fwd_hit;
      fwd_data_q <= fwd_data;
    end
  end

  assign rd_result = fwd_sel ? fwd_data_q : ram_rdata;
`else
  assign rd_result = ram_rdata;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      RD_IDLE: begin
        if (rd_accept) begin
`ifdef VRAM_READ_FORWARD_EN
          state_nxt = fwd_hit ? RD_WAIT : RD_DRAIN;
`else
          state_nxt = RD_DRAIN;
`endif
        end
      end
      RD_DRAIN: if (empty) state_nxt = RD_ISSUE;
      RD_ISSUE: if (free_slot) state_nxt = RD_WAIT;
      RD_WAIT:  state_nxt = RD_IDLE;
      default:  state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      fifo_addr[wr_ptr] <= cpu_addr;
      fifo_data[wr_ptr] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RD_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      rd_addr      <= '0;
      cpu_rdata    <= '0;
      cpu_rd_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      cpu_rd_valid <= (state == RD_WAIT);
      if (state == RD_WAIT) cpu_rdata <= rd_result;
      if (rd_accept) rd_addr <= cpu_addr;
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_cpu_port.sv
// tb/tb_vram_cpu_port.sv - scoreboard bench for vram_cpu_port (default build)
module tb_vram_cpu_port;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_wr_req = 1'b0;
  logic          cpu_rd_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_busy;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rd_valid;
  logic          video_fetch = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic          ram_re;
  logic [DW-1:0] ram_rdata = '0;
  logic [2:0]    fifo_level;

  vram_cpu_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cpu_wr_req(cpu_wr_req), .cpu_rd_req(cpu_rd_req),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_rdata(cpu_rdata), .cpu_rd_valid(cpu_rd_valid),
    .video_fetch(video_fetch),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Synchronous single-port video RAM model
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= ram[ram_addr];
  end

  int n_checks = 0;
  int n_fail = 0;
  int wr_seen = 0;

  logic [AW+DW-1:0] exp_wr[$];
  logic [DW-1:0]    exp_rd[$];
  logic [DW-1:0]    shadow [int];
  logic [AW+DW-1:0] exp_w;
  logic [DW-1:0]    exp_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event expected none at %0t", name, $time);
  endtask

  // Monitor: compares every RAM write and every read completion against the queues
  always @(negedge clk) begin
    if (reset) begin
      if (ram_we || ram_re) flag("strobe_in_reset");
    end else begin
      if (ram_we) begin
        wr_seen++;
        check("we_free_slot", 32'(video_fetch), 32'd0);
        if (exp_wr.size() == 0) flag("unexpected_ram_we");
        else begin
          exp_w = exp_wr.pop_front();
          check("ram_write", 32'({ram_addr, ram_wdata}), 32'(exp_w));
        end
      end
      if (ram_re) check("re_free_slot", 32'(video_fetch), 32'd0);
      if (cpu_rd_valid) begin
        if (exp_rd.size() == 0) flag("unexpected_rd_valid");
        else begin
          exp_r = exp_rd.pop_front();
          check("rd_data", 32'(cpu_rdata), 32'(exp_r));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_not_busy(input string name);
    int n = 0;
    while (cpu_busy && n < 200) begin tick(); n++; end
    if (cpu_busy) flag(name);
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit track);
    cpu_wr_req = 1'b1; cpu_addr = a; cpu_wdata = d;
    wait_not_busy("write_accept_timeout");
    tick();
    cpu_wr_req = 1'b0;
    if (track) begin
      exp_wr.push_back({a, d});
      shadow[int'(a)] = d;
    end
  endtask

  task automatic cpu_read(input logic [AW-1:0] a);
    cpu_rd_req = 1'b1; cpu_addr = a;
    wait_not_busy("read_accept_timeout");
    tick();
    cpu_rd_req = 1'b0;
    exp_rd.push_back(shadow[int'(a)]);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_wr.size() != 0 || exp_rd.size() != 0 || cpu_busy || fifo_level != 0) && n < 300) begin
      tick(); n++;
    end
    if (n >= 300) flag(name);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    logic [7:0] pattern;
    pattern = 8'b0000_0001;

    // Reset state
    repeat (3) tick();
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_re", 32'(ram_re), 32'd0);
    check("rst_valid", 32'(cpu_rd_valid), 32'd0);
    check("rst_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_wdata", 32'(ram_wdata), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_busy", 32'(cpu_busy), 32'd0);

    // Write burst while the generator owns the port
    video_fetch = 1'b1;
    for (int i = 0; i < 4; i++) cpu_write(AW'(i), DW'(8'hA0 + i), 1'b1);
    check("burst_level", 32'(fifo_level), 32'd4);
    check("burst_busy_full", 32'(cpu_busy), 32'd1);
    repeat (2) tick();
    check("burst_held_level", 32'(fifo_level), 32'd4);
    base = wr_seen;
    video_fetch = 1'b0;
    tick();
    check("burst_level_after_pop", 32'(fifo_level), 32'd3);
    check("burst_busy_drop", 32'(cpu_busy), 32'd0);
    repeat (3) tick();
    check("burst_consecutive_writes", 32'(wr_seen - base), 32'd4);
    check("burst_level_empty", 32'(fifo_level), 32'd0);

    // Interleaved fetch pattern with two queued writes
    video_fetch = 1'b1;
    cpu_write(13'h0010, 8'h21, 1'b1);
    cpu_write(13'h0011, 8'h22, 1'b1);
    for (int i = 0; i < 16; i++) begin
      video_fetch = pattern[i % 8];
      tick();
    end
    video_fetch = 1'b0;
    wait_done("interleave_drain_timeout");
    cpu_read(13'h0010);
    wait_done("interleave_rd0_timeout");
    cpu_read(13'h0011);
    wait_done("interleave_rd1_timeout");

    // Read-after-write ordering behind a blocked port
    video_fetch = 1'b1;
    cpu_write(13'h1F80, 8'h5A, 1'b1);
    cpu_read(13'h1F80);
    repeat (5) tick();
    check("raw_busy_pending", 32'(cpu_busy), 32'd1);
    check("raw_write_still_queued", 32'(fifo_level), 32'd1);
    video_fetch = 1'b0;
    wait_done("raw_timeout");

    // Simultaneous write and read: write first, read on the following edge
    cpu_wr_req = 1'b1; cpu_rd_req = 1'b1; cpu_addr = 13'h0100; cpu_wdata = 8'h11;
    wait_not_busy("simul_timeout");
    tick();
    exp_wr.push_back({13'h0100, 8'h11});
    shadow[32'h100] = 8'h11;
    cpu_wr_req = 1'b0;
    check("simul_write_first_level", 32'(fifo_level), 32'd1);
    check("simul_read_not_yet", 32'(cpu_busy), 32'd0);
    tick();
    cpu_rd_req = 1'b0;
    exp_rd.push_back(8'h11);
    check("simul_read_accepted", 32'(cpu_busy), 32'd1);
    wait_done("simul_done_timeout");

    // Minimum read latency with empty FIFO and free slots
    cpu_rd_req = 1'b1; cpu_addr = 13'h0003;
    tick();
    cpu_rd_req = 1'b0;
    exp_rd.push_back(shadow[3]);
    n = 0;
    while (!cpu_rd_valid && n < 20) begin tick(); n++; end
    check("read_latency", 32'(n), 32'd3);
    wait_done("latency_done_timeout");

    // Reset asserted mid-drain discards buffered writes
    video_fetch = 1'b1;
    for (int i = 0; i < 3; i++) cpu_write(AW'(13'h0400 + i), DW'(8'hC0 + i), 1'b0);
    check("pre_reset_level", 32'(fifo_level), 32'd3);
    video_fetch = 1'b0;
    reset = 1'b1;
    tick();
    check("mid_reset_level", 32'(fifo_level), 32'd0);
    check("mid_reset_we", 32'(ram_we), 32'd0);
    check("mid_reset_busy", 32'(cpu_busy), 32'd0);
    reset = 1'b0;
    base = wr_seen;
    repeat (10) tick();
    check("post_reset_no_writes", 32'(wr_seen - base), 32'd0);
    check("post_reset_level", 32'(fifo_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
